// File: rtl/im_boot_sched.sv
// Instruction-memory boot scheduler: loads a program into IM, hands the IM read port to fetch, halts on stop.
// Optional IM_BOOT_CHECKSUM_EN builds an additive checksum of the loaded words; otherwise checksum is tied to 0.
//
// state  | meaning
// IDLE   | after reset; core held in reset, waiting for start
// LOAD   | accepting loader words and writing them into IM
// RUN    | core released; IM address follows fetch_addr
// HALT   | stop seen; core held, counters frozen, start reloads
module im_boot_sched #(
   parameter int ADDR_W = 7,
   parameter int DEPTH  = 128,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              ld_valid,
   input  logic [31:0]       ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              stop_in,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_din,
   output logic              im_we,
   output logic              core_run,
   output logic              halted,
   output logic [ADDR_W:0]   load_count,
   output logic              load_err,
   output logic [CNT_W-1:0]  run_cycles,
   output logic [31:0]       checksum
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
   logic [ADDR_W:0]   load_count_q, load_count_d;
   logic              load_err_q, load_err_d;
   logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
   logic              core_run_q;
   logic              enter_load;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         hold_addr_q  <= '0;
         load_count_q <= '0;
         load_err_q   <= 1'b0;
         run_cycles_q <= '0;
         core_run_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         hold_addr_q  <= hold_addr_d;
         load_count_q <= load_count_d;
         load_err_q   <= load_err_d;
         run_cycles_q <= run_cycles_d;
         // core_run comes straight off a flop so the fetch unit's reset never glitches
         core_run_q   <= (state_d == S_RUN);
      end
   end

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      hold_addr_d  = hold_addr_q;
      load_count_d = load_count_q;
      load_err_d   = load_err_q;
      run_cycles_d = run_cycles_q;
      enter_load   = 1'b0;
      ld_ready     = 1'b0;
      im_we        = 1'b0;
      im_addr      = '0;
      im_din       = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_LOAD;
               enter_load = 1'b1;
            end
         end
         S_LOAD: begin
            ld_ready = 1'b1;
            im_addr  = wr_ptr_q;
            im_din   = ld_data;
            im_we    = ld_valid;
            if (ld_valid) begin
               load_count_d = load_count_q + (ADDR_W+1)'(1);
               // pointer parks on the last word rather than wrapping
               if (ld_last || (wr_ptr_q == LAST_PTR)) begin
                  state_d    = S_RUN;
                  load_err_d = ~ld_last;
               end else begin
                  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               end
            end
         end
         S_RUN: begin
            im_addr     = fetch_addr;
            hold_addr_d = fetch_addr;
            if (run_cycles_q != '1) begin
               run_cycles_d = run_cycles_q + CNT_W'(1);
            end
            if (stop_in) begin
               state_d = S_HALT;
            end
         end
         S_HALT: begin
            im_addr = hold_addr_q;
            if (start) begin
               state_d    = S_LOAD;
               enter_load = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (enter_load) begin
         wr_ptr_d     = '0;
         load_count_d = '0;
         load_err_d   = 1'b0;
         run_cycles_d = '0;
      end
   end

`ifdef IM_BOOT_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;
   logic        accept;

   always_comb begin
      accept     = (state_q == S_LOAD) && ld_valid;
      checksum_d = checksum_q;
      if (enter_load) begin
         checksum_d = '0;
      end else if (accept) begin
         checksum_d = checksum_q + ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

   assign core_run   = core_run_q;
   assign halted     = (state_q == S_HALT);
   assign load_count = load_count_q;
   assign load_err   = load_err_q;
   assign run_cycles = run_cycles_q;

endmodule
